// File: rtl/seg7_digit_driver_if.sv
// Seven-segment display bus between the BCD time counters and the digit driver.
//   digit_in    packed BCD, digit i = [4i+3:4i], digit 0 = least significant
//   load        latch digit_in on this edge
//   lz_en       leading-zero blanking enable
//   blink_mask  per-digit blink enable
//   lamp_test   force every segment on
//   hex_out     active-low segments, digit i = [7i+6:7i], bit0 = a .. bit6 = g
//   err         some latched digit is not a BCD value
//   blink_phase 1 while blinking digits are blanked
interface seg7_digit_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digit_in;
  logic                    load;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lamp_test;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    err;
  logic                    blink_phase;

  modport master (
    output digit_in, load, lz_en, blink_mask, lamp_test,
    input  hex_out, err, blink_phase
  );

  modport slave (
    input  digit_in, load, lz_en, blink_mask, lamp_test,
    output hex_out, err, blink_phase
  );
endinterface

// File: rtl/seg7_digit_driver.sv
// N-digit seven-segment driver for the time display path.
// Latches a packed BCD word on load, then every cycle registers the active-low
// segment pattern for each digit with lamp test, blink, leading-zero blanking
// and a dash for non-BCD digits. err flags any latched non-BCD digit.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   bus  display bus (slave side): digit_in/load/lz_en/blink_mask/lamp_test in,
//        hex_out/err/blink_phase out
module seg7_digit_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int BLINK_DIV     = 25_000_000,
  parameter int LZ_MIN_DIGITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_digit_driver_if.slave  bus
);

  localparam int          CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_ALL   = 7'b0000000;

  // Stage 1: latched digits
  logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
  logic                    valid_q, valid_d;

  // Blink timebase
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;

  // Stage 2: registered display
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    err_q, err_d;

  // Decode scratch
  logic [3:0]              nib;
  logic [6:0]              seg;
  logic                    zero_above;
  logic                    lz_blank;
  logic                    any_bad;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    digit_d = digit_q;
    valid_d = valid_q;
    if (bus.load) begin
      digit_d = bus.digit_in;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Walk from the MSD down: zero_above stays set only while this digit and
  // every higher one are zero, so the first nonzero (or non-BCD) digit ends
  // the blanking run.
  always_comb begin
    hex_d      = '0;
    nib        = '0;
    seg        = SEG_BLANK;
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    any_bad    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib        = digit_q[4*i +: 4];
      zero_above = zero_above & (nib == 4'd0);
      lz_blank   = bus.lz_en & zero_above & (i >= LZ_MIN_DIGITS);
      if (nib > 4'd9) begin
        any_bad = 1'b1;
      end
      if (bus.lamp_test) begin
        seg = SEG_ALL;
      end else if (!valid_q) begin
        seg = SEG_BLANK;
      end else if (phase_q && bus.blink_mask[i]) begin
        seg = SEG_BLANK;
      end else if (lz_blank) begin
        seg = SEG_BLANK;
      end else begin
        seg = seg_decode(nib);
      end
      hex_d[7*i +: 7] = seg;
    end
    err_d = valid_q & any_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= '1;
      err_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  assign bus.hex_out     = hex_q;
  assign bus.err         = err_q;
  assign bus.blink_phase = phase_q;

endmodule
